// File: rtl/cache_data_array.sv
// -----------------------------------------------------------------------------
// cache_data_array
//
// Multi-way cache data store. Holds WAYS independent ways of DEPTH lines, each
// line DATA_W bits wide. Writes use per-byte enables. Reads are registered,
// with one cycle of latency and a valid strobe. After every reset the array
// runs a zero-fill sweep. The sweep clears one {way,line} entry per cycle. The
// array does not accept requests until every entry has been cleared.
//
// Optional feature (compile-time macro CACHE_DATA_PARITY_EN):
//   When defined, the array stores one even-parity bit per data byte. A read
//   whose stored parity disagrees with the recomputed parity of the data
//   raises o_parity_err together with o_rvalid.
//   When undefined, there is no parity storage and no o_parity_err port.
//
// Ports:
//   i_clk         clock; all state updates on the rising edge
//   i_reset       asynchronous, active-high reset
//   i_req         request strobe, accepted only while o_ready=1
//   i_write       1 = write, 0 = read (qualified by i_req)
//   i_way         target way
//   i_addr        line index
//   i_be          byte enables for writes (ignored on reads)
//   i_data        write data
//   o_ready       array accepts requests (1 after the sweep, until reset)
//   o_init_done   sticky flag: post-reset sweep completed
//   o_rvalid      o_data holds a fresh read result this cycle
//   o_data        registered read data; holds its value between reads
//   o_parity_err  (CACHE_DATA_PARITY_EN only) parity mismatch on this read
// -----------------------------------------------------------------------------
module cache_data_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int WAYS   = 4,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req,
    input  logic                i_write,
    input  logic [WAY_W-1:0]    i_way,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [DATA_W-1:0]   i_data,
    output logic                o_ready,
    output logic                o_init_done,
    output logic                o_rvalid,
`ifdef CACHE_DATA_PARITY_EN
    output logic                o_parity_err,
`endif
    output logic [DATA_W-1:0]   o_data
);

    localparam int NB      = DATA_W / 8;
    localparam int ENTRIES = WAYS * DEPTH;
    localparam int IDX_W   = $clog2(ENTRIES);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // -------------------------------------------------------------------------
    // Storage: way-major flat index {way, line}
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [ENTRIES];

    logic [IDX_W-1:0] req_idx;

    if (WAYS > 1) begin : g_multi_way
        assign req_idx = {i_way, i_addr};
    end else begin : g_single_way
        assign req_idx = i_addr;
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   cnt_q,       cnt_d;
    logic               ready_q,     ready_d;
    logic               init_done_q, init_done_d;
    logic               rvalid_q,    rvalid_d;
    logic [DATA_W-1:0]  data_q,      data_d;

    logic               accept;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [NB-1:0]      wr_be;
    logic [DATA_W-1:0]  wr_data;
    logic [DATA_W-1:0]  rd_word;

    assign accept  = ready_q & i_req;
    assign rd_word = mem_q[req_idx];

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        init_done_d = init_done_q;
        wr_en       = 1'b0;
        wr_idx      = req_idx;
        wr_be       = i_be;
        wr_data     = i_data;

        case (state_q)
            ST_INIT: begin
                // Sweep: clear entry cnt_q with every byte enabled.
                wr_en   = 1'b1;
                wr_idx  = cnt_q;
                wr_be   = '1;
                wr_data = '0;
                if (cnt_q == IDX_W'(ENTRIES - 1)) begin
                    // The last entry is still cleared this cycle.
                    // Ready is asserted from the next cycle onward.
                    state_d     = ST_RUN;
                    ready_d     = 1'b1;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                wr_en = accept & i_write;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Read data is captured only on an accepted read, so o_data holds
        // its previous value between reads.
        rvalid_d = accept & ~i_write;
        data_d   = rvalid_d ? rd_word : data_q;
    end

`ifdef CACHE_DATA_PARITY_EN
    logic [NB-1:0] par_q [ENTRIES];
    logic [NB-1:0] par_calc;
    logic          perr_q, perr_d;

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            par_calc[b] = ^rd_word[8*b +: 8];
        end
        perr_d = rvalid_d & (|(par_calc ^ par_q[req_idx]));
    end
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments only. This keeps
        // every flop sampling values from before the edge.
        if (i_reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            rvalid_q    <= 1'b0;
            data_q      <= '0;
`ifdef CACHE_DATA_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            rvalid_q    <= rvalid_d;
            data_q      <= data_d;
`ifdef CACHE_DATA_PARITY_EN
            perr_q      <= perr_d;
`endif
        end
    end

    // NOTE: the storage array deliberately has no reset. The post-reset sweep
    // clears it, so it can map onto RAM rather than resettable flops.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
`ifdef CACHE_DATA_PARITY_EN
                    // Unwritten bytes keep their stored parity bit.
                    par_q[wr_idx][b]        <= ^wr_data[8*b +: 8];
`endif
                end
            end
        end
    end

    assign o_ready     = ready_q;
    assign o_init_done = init_done_q;
    assign o_rvalid    = rvalid_q;
    assign o_data      = data_q;
`ifdef CACHE_DATA_PARITY_EN
    assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_cache_data_array.sv
// -----------------------------------------------------------------------------
// tb_cache_data_array
//
// Directed bench for cache_data_array with the default parameters
// (DATA_W=32, DEPTH=256, WAYS=4). Every expected value below is worked out by
// hand. With CACHE_DATA_PARITY_EN defined, the bench also exercises the
// o_parity_err output.
// -----------------------------------------------------------------------------
module tb_cache_data_array;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 256;
    localparam int WAYS    = 4;
    localparam int ADDR_W  = 8;
    localparam int WAY_W   = 2;
    localparam int NB      = DATA_W / 8;
    localparam int SWEEP   = WAYS * DEPTH;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_req;
    logic              i_write;
    logic [WAY_W-1:0]  i_way;
    logic [ADDR_W-1:0] i_addr;
    logic [NB-1:0]     i_be;
    logic [DATA_W-1:0] i_data;
    logic              o_ready;
    logic              o_init_done;
    logic              o_rvalid;
    logic [DATA_W-1:0] o_data;
`ifdef CACHE_DATA_PARITY_EN
    logic              o_parity_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [DATA_W-1:0] last_data;

    cache_data_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .WAYS   (WAYS)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req        (i_req),
        .i_write      (i_write),
        .i_way        (i_way),
        .i_addr       (i_addr),
        .i_be         (i_be),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .o_init_done  (o_init_done),
        .o_rvalid     (o_rvalid),
`ifdef CACHE_DATA_PARITY_EN
        .o_parity_err (o_parity_err),
`endif
        .o_data       (o_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request at a negedge and return at the following negedge.
    // At that point o_rvalid/o_data show the result of this request.
    task automatic issue(input logic wr, input int way, input int addr,
                         input logic [NB-1:0] be, input logic [DATA_W-1:0] data);
        i_req   = 1'b1;
        i_write = wr;
        i_way   = WAY_W'(way);
        i_addr  = ADDR_W'(addr);
        i_be    = be;
        i_data  = data;
        @(negedge i_clk);
    endtask

    task automatic idle();
        i_req   = 1'b0;
        i_write = 1'b0;
        @(negedge i_clk);
    endtask

    // Write (checking that no rvalid pulse occurs and o_data holds).
    task automatic do_write(input string tag, input int way, input int addr,
                            input logic [NB-1:0] be, input logic [DATA_W-1:0] data);
        issue(1'b1, way, addr, be, data);
        check({tag, ".wr_rvalid"}, 64'(o_rvalid), 64'd0);
        check({tag, ".wr_hold"},   64'(o_data),   64'(last_data));
    endtask

    task automatic do_read(input string tag, input int way, input int addr,
                           input logic [DATA_W-1:0] exp);
        issue(1'b0, way, addr, '0, '0);
        check({tag, ".rvalid"}, 64'(o_rvalid), 64'd1);
        check({tag, ".data"},   64'(o_data),   64'(exp));
        last_data = exp;
    endtask

    // Called at the negedge where reset has just been released. Counts rising
    // edges until o_ready rises. When junk is set, requests are also driven
    // throughout INIT. These requests must have no effect.
    task automatic wait_sweep(input string tag, input bit junk);
        int n;
        int rv_seen;
        n = 0;
        rv_seen = 0;
        while (n < 4 * SWEEP) begin
            if (junk) begin
                i_req   = 1'b1;
                i_write = n[0];
                i_way   = 2'd0;
                i_addr  = 8'd7;
                i_be    = 4'hF;
                i_data  = 32'hFFFF_FFFF;
            end
            @(negedge i_clk);
            n++;
            if (o_rvalid) rv_seen++;
            if (o_ready) break;
        end
        i_req   = 1'b0;
        i_write = 1'b0;
        check({tag, ".sweep_cycles"}, 64'(n), 64'(SWEEP));
        check({tag, ".init_done"}, 64'(o_init_done), 64'd1);
        check({tag, ".no_rvalid_in_init"}, 64'(rv_seen), 64'd0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_req   = 1'b0;
        i_write = 1'b0;
        i_way   = '0;
        i_addr  = '0;
        i_be    = '0;
        i_data  = '0;
        last_data = '0;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst.ready",     64'(o_ready),     64'd0);
        check("rst.init_done", 64'(o_init_done), 64'd0);
        check("rst.rvalid",    64'(o_rvalid),    64'd0);
        check("rst.data",      64'(o_data),      64'd0);

        // Post-reset sweep
        i_reset = 1'b0;
        wait_sweep("sweep1", 1'b0);
        do_read("rd_w3_l255", 3, 255, 32'h0000_0000);
        do_read("rd_w0_l0",   0, 0,   32'h0000_0000);
        idle();
        check("idle.rvalid", 64'(o_rvalid), 64'd0);
        check("idle.hold",   64'(o_data),   64'(last_data));

        // Full write/read, then a different way at the same line
        do_write("full", 2, 8'h5A, 4'hF, 32'hDEAD_BEEF);
        do_read("full", 2, 8'h5A, 32'hDEAD_BEEF);
        do_read("other_way", 1, 8'h5A, 32'h0000_0000);

        // Byte enables: 0101 replaces bytes 0 and 2 only
        do_write("be0101", 2, 8'h5A, 4'b0101, 32'h1122_3344);
        do_read("be0101", 2, 8'h5A, 32'hDE22_BE44);
        do_write("be0000", 2, 8'h5A, 4'b0000, 32'h5566_7788);
        do_read("be0000", 2, 8'h5A, 32'hDE22_BE44);

        // Back-to-back write/read across 4 ways x 8 lines, no idle cycles
        for (int w = 0; w < 4; w++) begin
            for (int a = 0; a < 8; a++) begin
                logic [DATA_W-1:0] v;
                v = 32'hA500_0000 | (w << 12) | (a << 4) | 32'h3;
                do_write("b2b", w, a * 29, 4'hF, v);
                do_read("b2b", w, a * 29, v);
            end
        end
        // First entry again, to confirm that later writes did not disturb it
        do_read("b2b_recheck", 0, 0, 32'hA500_0003);

        // Reset mid-operation and mid-sweep
        do_write("pre_rst", 0, 7, 4'hF, 32'hCAFE_F00D);
        do_read("pre_rst", 0, 7, 32'hCAFE_F00D);
        i_req   = 1'b0;
        i_reset = 1'b1;
        #1;
        check("async_rst.ready",     64'(o_ready),     64'd0);
        check("async_rst.init_done", 64'(o_init_done), 64'd0);
        check("async_rst.data",      64'(o_data),      64'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (500) @(negedge i_clk);
        check("mid_sweep.ready", 64'(o_ready), 64'd0);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        check("mid_sweep_rst.data", 64'(o_data), 64'd0);
        i_reset = 1'b0;
        last_data = '0;
        wait_sweep("sweep2", 1'b1);
        do_read("post_rst_w0_l7", 0, 7, 32'h0000_0000);
        do_read("post_rst_w2_5a", 2, 8'h5A, 32'h0000_0000);

`ifdef CACHE_DATA_PARITY_EN
        do_write("par", 0, 1, 4'hF, 32'h0000_00FF);
        do_read("par_clean", 0, 1, 32'h0000_00FF);
        check("par_clean.err", 64'(o_parity_err), 64'd0);
        dut.mem_q[1][0] = 1'b0;
        do_read("par_bad", 0, 1, 32'h0000_00FE);
        check("par_bad.err", 64'(o_parity_err), 64'd1);
        idle();
        check("par_idle.err", 64'(o_parity_err), 64'd0);
`endif

        idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_data_array.md
Name: cache_data_array

Overview:
- Parametrised, multi-way successor to the single-way 256x32 cache data store; sits between the PLRU cache controller and the data path.
- Stores WAYS independent ways of DEPTH lines, each line DATA_W bits wide.
- Provides byte-enable writes and a registered, one-cycle-latency read with a valid strobe.
- Runs a hardware zero-initialisation sweep after reset, so the controller never reads undefined data.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 256, lines per way; must be a power of two, at least 2.
- WAYS, 4, number of ways; must be a power of two, at least 1.
- ADDR_W, $clog2(DEPTH), line index width (derived; do not override).
- WAY_W, (WAYS>1 ? $clog2(WAYS) : 1), way select width (derived).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_req  input  1  request strobe; accepted only when o_ready=1.
- i_write  input  1  1 = write, 0 = read; qualified by i_req.
- i_way  input  WAY_W  target way.
- i_addr  input  ADDR_W  line index.
- i_be  input  DATA_W/8  byte enables for writes; ignored on reads.
- i_data  input  DATA_W  write data.
- o_ready  output  1  array can accept a request this cycle.
- o_init_done  output  1  sticky; 1 once the post-reset sweep has completed.
- o_rvalid  output  1  o_data holds a fresh read result this cycle.
- o_data  output  DATA_W  read data, registered.

Behaviour:
- Reset values (asynchronous, while i_reset=1):
  - o_ready=0, o_init_done=0, o_rvalid=0, o_data=0.
  - FSM in INIT, sweep counter=0.
- FSM states:
  - INIT: writes all-zero to entry {way,line} = counter, one entry per cycle. Counter increments 0..WAYS*DEPTH-1. o_ready=0; i_req is ignored, with no side effects.
  - INIT to RUN: on the cycle the counter reaches WAYS*DEPTH-1 (that entry is still cleared that cycle). o_ready and o_init_done go to 1 on the next cycle.
  - RUN: o_ready=1 permanently. There is no path back to INIT except reset.
- Sweep duration: exactly WAYS*DEPTH cycles from the first rising edge after reset deassertion to o_ready=1.
- Reset mid-sweep or mid-operation: all state returns to reset values and the sweep restarts from counter 0. Array contents are not guaranteed until the new sweep completes.
- Read (RUN, i_req=1, i_write=0) accepted at edge T:
  - o_rvalid=1 and o_data=array[i_way][i_addr] during the cycle after T.
  - o_rvalid=0 in every cycle with no read accepted.
  - o_data holds its last value when o_rvalid=0.
- Write (RUN, i_req=1, i_write=1) accepted at edge T:
  - Byte k of the entry is replaced by i_data[8k+7:8k] only where i_be[k]=1; other bytes are unchanged.
  - i_be all-zero leaves the entry unchanged.
  - No o_rvalid pulse; o_data is unchanged.
- Single port: at most one request per cycle. Back-to-back requests every cycle are supported at full throughput.
- Read-after-write: a read issued the cycle after a write to the same {way,line} returns the post-write data. No stall and no bypass path; the synchronous array update guarantees this.
- Out-of-range inputs cannot occur; all index widths are exact powers of two.
- The storage is behavioural (flop/inferred RAM), so a macro-specific wrapper is not required.

Optional Feature:
- Macro: CACHE_DATA_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte. It is computed from i_data on writes; the sweep writes parity 0 (zero data has parity 0).
  - Extra output o_parity_err (1 bit, reset 0) is asserted together with o_rvalid when any stored parity bit mismatches the recomputed parity of the read byte; otherwise it is 0.
  - On a partial write, parity bits of unwritten bytes are retained.
- Undefined: no parity storage, no o_parity_err port; all other behaviour is identical.

Test Plan:
- Post-reset sweep, defaults: deassert i_reset -> o_ready=0 for exactly 1024 cycles, then o_ready=1 and o_init_done=1. Reads of way 3 line 255 and way 0 line 0 return 0x00000000 with o_rvalid one cycle after the request.
- Full write/read: write way 2, addr 0x5A, be=4'hF, data 0xDEADBEEF; read it the next cycle -> o_rvalid=1 one cycle later with o_data=0xDEADBEEF. Way 1 same addr reads 0x00000000.
- Byte enables: after the previous test, write be=4'b0101, data 0x11223344 to way 2 addr 0x5A -> read returns 0xDE22BE44. Then write be=4'b0000 -> entry is unchanged.
- Back-to-back: alternate write/read every cycle across 4 ways x 8 addresses with distinct data -> every read returns the latest data, o_rvalid pulses only for reads, and there are no stall cycles.
- Reset mid-operation: write 0xCAFEF00D to way 0 addr 7, then assert i_reset for 2 cycles during cycle 500 of a fresh sweep -> sweep restarts from 0 and takes 1024 cycles. Afterwards way 0 addr 7 reads 0. Requests driven during INIT have no effect.
- With CACHE_DATA_PARITY_EN: write 0x000000FF, force-flip a stored data bit of byte 0 -> the read asserts o_parity_err with o_rvalid. An uncorrupted read returns o_parity_err=0.
